// File: rtl/io_map_pkg.sv
// io_map_pkg: shared constants for the memory-mapped I/O block.
//   - default base address of the I/O region
//   - byte offsets of every register, relative to the base
//   - bit positions inside the status word
package io_map_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;

  // Register offsets (byte addresses relative to the base).
  localparam logic [7:0] OFF_STATUS  = 8'h00;  // R : {tx_ovr, rx_full, ~tx_full}
  localparam logic [7:0] OFF_RX      = 8'h04;  // R : received byte
  localparam logic [7:0] OFF_TX      = 8'h08;  // W : byte to transmit
  localparam logic [7:0] OFF_CYCLE   = 8'h10;  // R : cycle count
  localparam logic [7:0] OFF_INST    = 8'h14;  // R : instruction count
  localparam logic [7:0] OFF_CNT_CLR = 8'h18;  // W : zero all counters
  localparam logic [7:0] OFF_BR      = 8'h1C;  // R : branch count
  localparam logic [7:0] OFF_BR_OK   = 8'h20;  // R : correct-branch count

  // Status word bit indices.
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_OVR   = 2;

endpackage

// File: rtl/io_counter.sv
// io_counter: free-standing performance counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one this cycle
//   clr        : zero next cycle; wins over inc
//   q          : current count, wraps modulo 2^CNT_W
module io_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block serving the memory stage.
//   clk, rst_n        : clock, asynchronous active-low reset
//   io_addr/io_wdata  : word-aligned byte address and store data
//   io_we/io_wea      : store pulse and byte mask
//   io_re/io_rdata    : load pulse; read data registered, valid one cycle later
//   inst_retired, br_retired, br_correct : performance counter events
//   uart_tx_*         : one-entry TX buffer toward the transmitter
//   uart_rx_*         : one-entry RX buffer from the receiver
//
// Handshake semantics (both UART ports): a byte moves in exactly the cycles
// where valid && ready are both high at the rising clock edge. The source
// holds valid and data stable until that happens; ready may change freely.
module mmio_ctrl
  import io_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic [3:0]  io_wea,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic        inst_retired,
  input  logic        br_retired,
  input  logic        br_correct,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  // ---------------------------------------------------------------- decode
  logic [31:0] off_full;
  logic [7:0]  off;
  logic        hit;
  logic        wr_en;
  logic        rd_en;

  assign off_full = io_addr - BASE_ADDR;
  assign hit      = (off_full[31:8] == 24'h0);
  assign off      = off_full[7:0];
  assign wr_en    = io_we && hit;
  // A simultaneous store wins: the load is dropped with all its side effects.
  assign rd_en    = io_re && !io_we;

  logic tx_store, cnt_clr, stat_rd, rx_rd;
  assign tx_store = wr_en && (off == OFF_TX) && io_wea[0];
  assign cnt_clr  = wr_en && (off == OFF_CNT_CLR);
  assign stat_rd  = rd_en && hit && (off == OFF_STATUS);
  assign rx_rd    = rd_en && hit && (off == OFF_RX);

  // ------------------------------------------------------------- TX buffer
  logic tx_full, tx_ovr, tx_hs;
  assign tx_hs         = tx_full && uart_tx_ready;
  assign uart_tx_valid = tx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full      <= 1'b0;
      uart_tx_data <= 8'h00;
    end else if (tx_store && !tx_full) begin
      tx_full      <= 1'b1;
      uart_tx_data <= io_wdata[7:0];
    end else if (tx_hs) begin
      tx_full      <= 1'b0;
    end
  end

  // A store that finds the buffer full is lost, even when the handshake
  // frees the entry in that same cycle. A status load clears the flag after
  // the value has been sampled into the read mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovr <= 1'b0;
    end else if (tx_store && tx_full) begin
      tx_ovr <= 1'b1;
    end else if (stat_rd) begin
      tx_ovr <= 1'b0;
    end
  end

  // ------------------------------------------------------------- RX buffer
  logic       rx_full, rx_full_d, rx_hs;
  logic [7:0] rx_byte;
  assign rx_hs = uart_rx_valid && uart_rx_ready;

  // Load-clear and capture never coincide: capture needs ready (=empty),
  // and a load of an empty buffer has no effect.
  always_comb begin
    rx_full_d = rx_full;
    if (rx_rd && rx_full) begin
      rx_full_d = 1'b0;
    end else if (rx_hs) begin
      rx_full_d = 1'b1;
    end
  end

  // ready is its own flop, loaded from the next-state of rx_full, so the
  // receiver never sees a combinational path from io_re.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full       <= 1'b0;
      rx_byte       <= 8'h00;
      uart_rx_ready <= 1'b1;
    end else begin
      rx_full       <= rx_full_d;
      uart_rx_ready <= ~rx_full_d;
      if (rx_hs) begin
        rx_byte <= uart_rx_data;
      end
    end
  end

  // -------------------------------------------------------------- counters
  logic [CNT_W-1:0] cyc_q, inst_q, br_q, br_ok_q;

  io_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst_n(rst_n), .inc(1'b1), .clr(cnt_clr), .q(cyc_q)
  );
  io_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk(clk), .rst_n(rst_n), .inc(inst_retired), .clr(cnt_clr), .q(inst_q)
  );
  io_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk(clk), .rst_n(rst_n), .inc(br_retired), .clr(cnt_clr), .q(br_q)
  );
  io_counter #(.CNT_W(CNT_W)) u_br_ok_cnt (
    .clk(clk), .rst_n(rst_n), .inc(br_retired && br_correct), .clr(cnt_clr),
    .q(br_ok_q)
  );

  // ------------------------------------------------------- read mux / rdata
  logic [31:0] rmux;

  always_comb begin
    rmux = 32'h0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          rmux[ST_TX_READY] = ~tx_full;
          rmux[ST_RX_FULL]  = rx_full;
          rmux[ST_TX_OVR]   = tx_ovr;
        end
        OFF_RX:    rmux = {24'h0, rx_byte};
        OFF_CYCLE: rmux = 32'(cyc_q);
        OFF_INST:  rmux = 32'(inst_q);
        OFF_BR:    rmux = 32'(br_q);
        OFF_BR_OK: rmux = 32'(br_ok_q);
        default:   rmux = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata <= 32'h0;
    end else if (rd_en) begin
      io_rdata <= rmux;
    end
  end

  // Upper store bytes are not used by any register.
  logic unused_bits;
  assign unused_bits = ^{io_wdata[31:8], io_wea[3:1]};

endmodule
